e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu.sv | 177 +++++++++++++++++
 tb/tb_e_mdu.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu -- multiply/divide unit holding the HI/LO register pair.
// A launched mult/multu (and div/divu when built with MDU_DIV_EN) computes its
// result up front into temp registers, then holds busy for a fixed number of
// cycles before committing to HI/LO. mthi/mtlo write directly when idle.
// Optional feature macro: MDU_DIV_EN (compiles in the div/divu datapath).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  HILOOP,
  input  logic [1:0]  WHILO,
  input  logic [1:0]  HILOSel_E,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HILO_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      temp_hi_reg, temp_hi_next;
  logic [31:0]      temp_lo_reg, temp_lo_next;

  logic        is_mult;
  logic        is_div;
  logic        launch;
  logic        hilo_wr;
  logic [63:0] op_result;

  // Operation decode; div/divu only count as real operations when compiled in.
  always_comb begin
    is_mult = (HILOOP == 3'b000) || (HILOOP == 3'b001);
`ifdef MDU_DIV_EN
    is_div  = (HILOOP == 3'b010) || (HILOOP == 3'b011);
`else
    is_div  = 1'b0;
`endif
    launch  = start && !Req && !busy_reg && (is_mult || is_div);
    // A launch in the same cycle wins over a direct HI/LO write.
    hilo_wr = !Req && !busy_reg && !launch && ((WHILO == 2'b00) || (WHILO == 2'b01));
  end

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = 64'($signed(A)) * 64'($signed(B));
  assign prod_u = {32'h0, A} * {32'h0, B};

`ifdef MDU_DIV_EN
  logic        [31:0] div_b;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               div_zero;

  // Division datapath. The divisor is never zero or all-ones on the actual
  // divide: zero leaves HI/LO alone anyway, and -1 is handled as a negate,
  // which avoids the INT_MIN / -1 overflow trap in some simulators.
  always_comb begin
    div_zero = (B == 32'h0);
    div_b    = (div_zero || (B == 32'hFFFF_FFFF)) ? 32'd1 : B;
    if (B == 32'hFFFF_FFFF) begin
      quo_s = 32'sd0 - $signed(A);
      rem_s = 32'sd0;
    end else begin
      quo_s = $signed(A) / $signed(div_b);
      rem_s = $signed(A) % $signed(div_b);
    end
    quo_u = A / div_b;
    rem_u = A % div_b;
  end
`endif

  // Result selection; a divide by zero re-captures the current HI/LO so the
  // commit at the end of the busy period leaves them unchanged.
  always_comb begin
    op_result = HILOOP[0] ? prod_u : unsigned'(prod_s);
`ifdef MDU_DIV_EN
    if (is_div) begin
      if (div_zero)
        op_result = {hi_reg, lo_reg};
      else if (HILOOP[0])
        op_result = {rem_u, quo_u};
      else
        op_result = {unsigned'(rem_s), unsigned'(quo_s)};
    end
`endif
  end

  // Next-state logic: launch/direct write in IDLE, countdown and commit in BUSY.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    busy_next    = busy_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    temp_hi_next = temp_hi_reg;
    temp_lo_next = temp_lo_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next   = BUSY;
          busy_next    = 1'b1;
          cnt_next     = is_div ? DIV_LOAD : MULT_LOAD;
          temp_hi_next = op_result[63:32];
          temp_lo_next = op_result[31:0];
        end else if (hilo_wr) begin
          if (WHILO[0])
            lo_next = A;
          else
            hi_next = A;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg <= CNT_ONE) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          cnt_next   = '0;
          hi_next    = temp_hi_reg;
          lo_next    = temp_lo_reg;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      hi_reg      <= 32'h0;
      lo_reg      <= 32'h0;
      temp_hi_reg <= 32'h0;
      temp_lo_reg <= 32'h0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      temp_hi_reg <= temp_hi_next;
      temp_lo_reg <= temp_lo_next;
    end
  end

  assign busy = busy_reg;

  // Read mux: always shows the committed HI/LO, never the pending result.
  always_comb begin
    case (HILOSel_E)
      2'b00:   HILO_out = hi_reg;
      2'b01:   HILO_out = lo_reg;
      default: HILO_out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu -- self-checking bench for e_mdu with a behavioural HI/LO model.
// Honours MDU_DIV_EN: div/divu are expected to work when it is defined and to
// behave as "none" otherwise.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  HILOOP;
  logic [1:0]  WHILO;
  logic [1:0]  HILOSel_E;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HILO_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .HILOOP(HILOOP), .WHILO(WHILO),
    .HILOSel_E(HILOSel_E), .Req(Req), .A(A), .B(B), .busy(busy), .HILO_out(HILO_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {HI,LO} after an operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] old_hi,
                                             input logic [31:0] old_lo);
    longint sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur, up;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    res = {old_hi, old_lo};
    case (op)
      3'b000: begin p = sa * sb; res = p; end
      3'b001: begin up = ua * ub; res = up; end
      3'b010: if (DIV_EN && b != 32'h0) begin
        q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        if ((sa < 0) != (sb < 0)) q = -q;
        r = sa - q * sb;
        res = {r[31:0], q[31:0]};
      end
      3'b011: if (DIV_EN && b != 32'h0) begin
        uq = ua / ub;
        ur = ua - uq * ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: ;
    endcase
    return res;
  endfunction

  function automatic int ref_cycles(input logic [2:0] op);
    if (op == 3'b000 || op == 3'b001) return MULT_N;
    if (op == 3'b010 || op == 3'b011) return DIV_EN ? DIV_N : 0;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    HILOSel_E = 2'b00; #1 h = HILO_out;
    HILOSel_E = 2'b01; #1 l = HILO_out;
    HILOSel_E = 2'b11; #1;
  endtask

  // Drive one start pulse and measure the busy period (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] w, input logic rq,
                        output int cyc, output logic old_ok);
    HILOOP = op; A = a; B = b; WHILO = w; Req = rq; start = 1'b1; HILOSel_E = 2'b00;
    step();
    start = 1'b0; HILOOP = 3'b111; WHILO = 2'b11; Req = 1'b0;
    A = $urandom; B = $urandom;
    cyc = 0;
    old_ok = 1'b1;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (HILO_out !== hi_m) old_ok = 1'b0;
      step();
    end
    HILOSel_E = 2'b11;
    $display("op=%03b A=%h B=%h Req=%0b WHILO=%02b busy_cycles=%0d", op, a, b, rq, w, cyc);
  endtask

  task automatic write_hilo(input logic [1:0] w, input logic [31:0] a, input logic rq);
    WHILO = w; A = a; Req = rq;
    step();
    WHILO = 2'b11; Req = 1'b0;
    $display("write WHILO=%02b A=%h Req=%0b", w, a, rq);
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    reset = 1'b1; start = 1'b0; HILOOP = 3'b111; WHILO = 2'b11; HILOSel_E = 2'b11;
    Req = 1'b0; A = '0; B = '0;
    step(); step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    read_hilo(h, l);
    checks++;
    if (h !== 32'h0 || l !== 32'h0) begin
      errors++; $display("FAIL reset_hilo: got HI=%h LO=%h expected 0/0", h, l);
    end
    reset = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    step();
  endtask

  task automatic test_mult();
    logic [2:0] op; logic [31:0] a, b, h, l; logic [63:0] exp; int cyc; logic old_ok;
    for (int i = 0; i < 8; i++) begin
      op = (i < 2) ? 3'(i) : 3'($urandom_range(0, 1));
      a  = (i < 2) ? 32'hFFFF_FFFF : $urandom;
      b  = (i < 2) ? 32'd2 : $urandom;
      exp = ref_result(op, a, b, hi_m, lo_m);
      run_op(op, a, b, 2'b11, 1'b0, cyc, old_ok);
      read_hilo(h, l);
      checks++;
      if (cyc != MULT_N) begin errors++; $display("FAIL mult_busy_len: got %0d expected %0d", cyc, MULT_N); end
      checks++;
      if (old_ok !== 1'b1) begin errors++; $display("FAIL mult_old_hi_during_busy: got changed expected %h", hi_m); end
      checks++;
      if ({h, l} !== exp) begin errors++; $display("FAIL mult_result: got %h_%h expected %h", h, l, exp); end
      hi_m = exp[63:32]; lo_m = exp[31:0];
    end
  endtask

  task automatic test_div();
    logic [2:0] op; logic [31:0] a, b, h, l; logic [63:0] exp; int cyc; logic old_ok;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin op = 3'b010; a = 32'hFFFF_FFF9; b = 32'd2; end
        1: begin op = 3'b011; a = 32'd7; b = 32'd0; end
        2: begin op = 3'b010; a = 32'd8; b = 32'd2; end
        3: begin op = 3'b010; a = $urandom; b = 32'd0; end
        default: begin
          op = 3'($urandom_range(2, 3)); a = $urandom;
          b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
          if (b == 32'hFFFF_FFFF) b = 32'd3;
          if ($urandom_range(0, 1) == 0) b = -b;
        end
      endcase
      exp = ref_result(op, a, b, hi_m, lo_m);
      run_op(op, a, b, 2'b11, 1'b0, cyc, old_ok);
      read_hilo(h, l);
      checks++;
      if (cyc != ref_cycles(op)) begin errors++; $display("FAIL div_busy_len: got %0d expected %0d", cyc, ref_cycles(op)); end
      checks++;
      if (old_ok !== 1'b1) begin errors++; $display("FAIL div_old_hi_during_busy: got changed expected %h", hi_m); end
      checks++;
      if ({h, l} !== exp) begin errors++; $display("FAIL div_result: got %h_%h expected %h", h, l, exp); end
`ifdef MDU_DIV_EN
      if (i == 0) begin
        checks++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
          errors++; $display("FAIL div_neg7_by_2: got HI=%h LO=%h expected FFFFFFFF/FFFFFFFD", h, l);
        end
      end
`else
      if (i == 2) begin
        checks++;
        if (cyc != 0 || h !== hi_m || l !== lo_m) begin
          errors++; $display("FAIL div_disabled: got busy_cycles=%0d HI=%h LO=%h expected 0 %h %h", cyc, h, l, hi_m, lo_m);
        end
      end
`endif
      hi_m = exp[63:32]; lo_m = exp[31:0];
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] h, l, a; logic [1:0] w;
    write_hilo(2'b01, 32'h1234_5678, 1'b0);
    lo_m = 32'h1234_5678;
    HILOSel_E = 2'b01; #1;
    checks++;
    if (HILO_out !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_read: got %h expected 12345678", HILO_out); end
    HILOSel_E = 2'b11; #1;
    checks++;
    if (HILO_out !== 32'h0) begin errors++; $display("FAIL sel_none: got %h expected 0", HILO_out); end
    for (int i = 0; i < 6; i++) begin
      w = 2'($urandom_range(0, 1)); a = $urandom;
      write_hilo(w, a, 1'b0);
      if (w[0]) lo_m = a; else hi_m = a;
      read_hilo(h, l);
      checks++;
      if (h !== hi_m || l !== lo_m) begin
        errors++; $display("FAIL mthi_mtlo: got HI=%h LO=%h expected %h %h", h, l, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_req_flush();
    logic [31:0] h, l; int cyc; logic old_ok;
    write_hilo(2'b01, 32'hA5A5_0001, 1'b1);
    write_hilo(2'b00, 32'hA5A5_0002, 1'b1);
    read_hilo(h, l);
    checks++;
    if (h !== hi_m || l !== lo_m) begin
      errors++; $display("FAIL req_blocks_write: got HI=%h LO=%h expected %h %h", h, l, hi_m, lo_m);
    end
    run_op(3'b000, $urandom, $urandom, 2'b11, 1'b1, cyc, old_ok);
    read_hilo(h, l);
    checks++;
    if (cyc != 0) begin errors++; $display("FAIL req_blocks_start: got busy_cycles=%0d expected 0", cyc); end
    checks++;
    if (h !== hi_m || l !== lo_m) begin
      errors++; $display("FAIL req_start_hilo: got HI=%h LO=%h expected %h %h", h, l, hi_m, lo_m);
    end
  endtask

  task automatic test_priority();
    logic [31:0] a, b, h, l; logic [63:0] exp; int cyc; logic old_ok;
    a = $urandom | 32'h1; b = $urandom | 32'h3;
    exp = ref_result(3'b001, a, b, hi_m, lo_m);
    run_op(3'b001, a, b, 2'b00, 1'b0, cyc, old_ok);
    read_hilo(h, l);
    checks++;
    if (cyc != MULT_N || {h, l} !== exp) begin
      errors++; $display("FAIL start_over_mthi: got cycles=%0d %h_%h expected %0d %h", cyc, h, l, MULT_N, exp);
    end
    hi_m = exp[63:32]; lo_m = exp[31:0];
  endtask

  task automatic test_reset_abort();
    logic [31:0] h, l; int seen_busy;
    write_hilo(2'b00, 32'hDEAD_0001, 1'b0);
    write_hilo(2'b01, 32'hDEAD_0002, 1'b0);
    HILOOP = 3'b000; A = 32'h0001_0000; B = 32'h0001_0000; start = 1'b1;
    step();
    start = 1'b0; HILOOP = 3'b111;
    step(); step();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    read_hilo(h, l);
    checks++;
    if (h !== 32'h0 || l !== 32'h0) begin errors++; $display("FAIL abort_hilo: got HI=%h LO=%h expected 0/0", h, l); end
    reset = 1'b0;
    hi_m = 32'h0; lo_m = 32'h0;
    seen_busy = 0;
    for (int i = 0; i < MULT_N + 3; i++) begin
      step();
      if (busy !== 1'b0) seen_busy++;
    end
    read_hilo(h, l);
    checks++;
    if (seen_busy != 0 || h !== 32'h0 || l !== 32'h0) begin
      errors++; $display("FAIL abort_no_commit: got busy_seen=%0d HI=%h LO=%h expected 0 0 0", seen_busy, h, l);
    end
    $display("reset abort at busy cycle 3 done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_mthi_mtlo();
    test_div();
    test_req_flush();
    test_priority();
    test_reset_abort();
    test_mult();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
